// File: rtl/period_meter_pkg.sv
// rtl/period_meter_pkg.sv - shared types and constants for the period meter
package period_meter_pkg;

    // Measurement state: waiting for the first edge, or timing between edges
    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    // Shortest interval the edge detector can resolve (one high, one low cycle)
    localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/period_meter_sync_edge_detect.sv
// rtl/period_meter_sync_edge_detect.sv - async input synchronizer with rising-edge pulse
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic n_rst,
    input  logic async_in,
    output logic level,
    output logic rise_pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    // Shift the asynchronous line through the synchronizer chain
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
        end
    end

    // Remember the previous synchronized level for edge detection
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_hist <= 1'b0;
        end else begin
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign level      = r_sync[SYNC_STAGES-1];
    assign rise_pulse = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule

// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures clk cycles between rising edges of an async event line
module period_meter
    import period_meter_pkg::*;
#(
    parameter int NUM_BITS    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                clear,
    input  logic                event_in,
    output logic [NUM_BITS-1:0] period,
    output logic                period_sat,
    output logic                period_valid,
    input  logic                period_ready,
    output logic                overrun
);

    localparam logic [NUM_BITS-1:0] C_ALL_ONES = '1;
    localparam logic [NUM_BITS-1:0] C_ONE      = {{(NUM_BITS-1){1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NUM_BITS-1:0] r_count;
    logic [NUM_BITS-1:0] r_period;
    logic                r_sat;
    logic                r_valid;
    logic                r_overrun;

    logic w_level;
    logic w_rise;
    logic w_edge;
    logic w_at_max;
    logic w_accept;
    logic w_count_en;
    logic w_result_evt;
    logic w_capture;
    logic w_drop;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .n_rst      (n_rst),
        .async_in   (event_in),
        .level      (w_level),
        .rise_pulse (w_rise)
    );

    // A rise pulse always coincides with a high synchronized level; the
    // qualification keeps the period boundary tied to the synchronized line.
    assign w_edge   = w_rise & w_level;
    assign w_at_max = (r_count == C_ALL_ONES);
    assign w_accept = r_valid & period_ready;

    // A result either replaces the pending one (free or being accepted now)
    // or is thrown away and flagged as an overrun.
    assign w_capture = w_result_evt & (~r_valid | period_ready);
    assign w_drop    = w_result_evt & r_valid & ~period_ready;

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: clear wins, first edge starts measuring, no timeout
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_edge) w_state_nxt = MEASURE;
                MEASURE: w_state_nxt = MEASURE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // FSM outputs: count while measuring, report a result on each later edge
    always_comb begin
        w_count_en   = 1'b0;
        w_result_evt = 1'b0;
        if (!clear) begin
            case (r_state)
                IDLE: begin
                    w_count_en   = 1'b0;
                    w_result_evt = 1'b0;
                end
                MEASURE: begin
                    w_count_en   = ~w_at_max;
                    w_result_evt = w_edge;
                end
                default: begin
                    w_count_en   = 1'b0;
                    w_result_evt = 1'b0;
                end
            endcase
        end
    end

    // Interval counter: restarts at 1 on every edge, saturates at all-ones
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (w_edge) begin
            r_count <= C_ONE;
        end else if (w_count_en) begin
            r_count <= r_count + C_ONE;
        end
    end

    // Result register: loads only on capture, holds across clear
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_period <= '0;
            r_sat    <= 1'b0;
        end else if (w_capture) begin
            r_period <= r_count;
            r_sat    <= w_at_max;
        end
    end

    // Valid flag: set by capture, cleared by consumption or clear
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_valid <= 1'b0;
        end else if (clear) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid <= 1'b1;
        end else if (w_accept) begin
            r_valid <= 1'b0;
        end
    end

    // Sticky overrun: a finished result was lost while one was still pending
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_overrun <= 1'b0;
        end else if (clear) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end
    end

    assign period       = r_period;
    assign period_sat   = r_sat;
    assign period_valid = r_valid;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - scoreboard bench for period_meter
module tb_period_meter;
    import period_meter_pkg::*;

    localparam int MAX16 = 65535;

    logic        clk;
    logic        n_rst;
    logic        clear;
    logic        event_in;
    logic [15:0] period;
    logic        period_sat;
    logic        period_valid;
    logic        period_ready;
    logic        overrun;

    logic        event8;
    logic [7:0]  period8;
    logic        sat8;
    logic        valid8;
    logic        ovr8;
    logic        clear8;
    logic        ready8;

    period_meter #(.NUM_BITS(16), .SYNC_STAGES(2)) u_dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .event_in     (event_in),
        .period       (period),
        .period_sat   (period_sat),
        .period_valid (period_valid),
        .period_ready (period_ready),
        .overrun      (overrun)
    );

    period_meter #(.NUM_BITS(8), .SYNC_STAGES(2)) u_dut8 (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear8),
        .event_in     (event8),
        .period       (period8),
        .period_sat   (sat8),
        .period_valid (valid8),
        .period_ready (ready8),
        .overrun      (ovr8)
    );

    typedef struct {
        int cap;
        int p;
        bit sat;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   k_prev = -1;
    int   n_checks = 0;
    int   n_pass = 0;
    bit   rand_ready = 0;

    bit   m_valid = 0;
    bit   m_ovr = 0;
    bit   m_sat = 0;
    int   m_period = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) period_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Rising edge on the main line; the expected interval is simply the
    // distance between consecutive rises, in clock cycles, capped at all-ones.
    task automatic rise_main();
        int   k;
        int   p;
        exp_t e;
        step();
        event_in = 1'b1;
        k = cyc + 1;
        if (k_prev >= 0) begin
            p     = k - k_prev;
            e.cap = k + 2;
            e.p   = (p > MAX16) ? MAX16 : p;
            e.sat = (p >= MAX16);
            sb_q.push_back(e);
        end
        k_prev = k;
    endtask

    task automatic tick(input int p, input int h);
        rise_main();
        repeat (h) step();
        event_in = 1'b0;
        repeat (p - h - 1) step();
    endtask

    // 8-bit instance: checks the previous interval with exact 3-edge latency
    task automatic tick8(input int gap_after, input bit expect_res,
                         input int exp_p, input bit exp_sat);
        step();
        event8 = 1'b1;
        step();
        step();
        chk("lat8_early", 64'(valid8), 64'(0));
        step();
        if (expect_res) chk("result8", {valid8, sat8, period8}, {1'b1, exp_sat, 8'(exp_p)});
        else            chk("first8_none", 64'(valid8), 64'(0));
        repeat (2) step();
        event8 = 1'b0;
        repeat (gap_after - 6) step();
    endtask

    // Scoreboard monitor: compares outputs every cycle, then advances the
    // expected handshake state to the next clock edge.
    always @(negedge clk) begin
        bit   accept;
        bit   hit;
        exp_t e;
        if (!n_rst) begin
            m_valid  = 0;
            m_ovr    = 0;
            m_sat    = 0;
            m_period = 0;
        end else begin
            chk("outputs", {period_valid, overrun, period_sat, period},
                {m_valid, m_ovr, m_sat, 16'(m_period)});
            accept = m_valid && period_ready;
            hit    = 0;
            while (sb_q.size() > 0 && sb_q[0].cap < cyc + 1) begin
                e = sb_q.pop_front();
                chk("sb_stale", 64'(e.cap), 64'(cyc + 1));
            end
            if (sb_q.size() > 0 && sb_q[0].cap == cyc + 1) begin
                e   = sb_q.pop_front();
                hit = 1;
            end
            if (clear) begin
                m_valid = 0;
                m_ovr   = 0;
            end else if (hit) begin
                if (!m_valid || accept) begin
                    m_period = e.p;
                    m_sat    = e.sat;
                    m_valid  = 1;
                end else begin
                    m_ovr = 1;
                end
            end else if (accept) begin
                m_valid = 0;
            end
        end
    end

    initial begin
        n_rst        = 1'b0;
        clear        = 1'b0;
        event_in     = 1'b0;
        period_ready = 1'b1;
        event8       = 1'b0;
        clear8       = 1'b0;
        ready8       = 1'b1;
        repeat (3) step();
        n_rst = 1'b1;

        // Quiet after reset
        for (int i = 0; i < 20; i++) begin
            step();
            chk("reset_quiet", {period_valid, overrun, period_sat, period},
                {1'b0, 1'b0, 1'b0, 16'd0});
            chk("reset_quiet8", {valid8, ovr8, sat8, period8}, {1'b0, 1'b0, 1'b0, 8'd0});
        end

        // Regular ticks every 100 cycles
        repeat (4) tick(100, 50);

        // Ready held low: first result held, later ones overrun
        tick(10, 5);
        period_ready = 1'b0;
        repeat (3) tick(10, 5);
        step();
        period_ready = 1'b1;
        step();
        period_ready = 1'b0;
        repeat (3) step();
        clear = 1'b1;
        k_prev = -1;
        step();
        clear = 1'b0;
        repeat (3) step();

        // Pending result replaced by P=7 in the same cycle it is accepted
        tick(20, 5);
        tick(7, 3);
        rise_main();
        step();
        step();
        period_ready = 1'b1;
        step();
        period_ready = 1'b0;
        event_in = 1'b0;
        repeat (5) step();
        period_ready = 1'b1;
        repeat (3) step();

        // Clear mid-measure with the line high
        rise_main();
        repeat (40) step();
        clear = 1'b1;
        k_prev = -1;
        step();
        clear = 1'b0;
        repeat (10) step();
        event_in = 1'b0;
        repeat (5) step();
        tick(33, 10);
        tick(33, 10);

        // Randomized periods and consumer back-pressure
        rand_ready = 1;
        for (int i = 0; i < 40; i++) begin
            int p;
            int h;
            p = $urandom_range(MIN_PERIOD, 40);
            h = $urandom_range(1, p - 1);
            tick(p, h);
        end
        rand_ready = 0;
        period_ready = 1'b1;
        repeat (5) step();

        // Asynchronous reset while a result is pending and a measure runs
        period_ready = 1'b0;
        tick(30, 10);
        @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        chk("async_reset", {period_valid, overrun, period_sat, period},
            {1'b0, 1'b0, 1'b0, 16'd0});
        sb_q.delete();
        k_prev = -1;
        step();
        step();
        n_rst = 1'b1;
        period_ready = 1'b1;
        repeat (3) tick(25, 5);

        // Saturation boundary on the narrow instance
        tick8(300, 0, 0, 0);
        tick8(255, 1, 255, 1);
        tick8(254, 1, 255, 1);
        tick8(100, 1, 254, 0);
        tick8(10, 1, 100, 0);

        repeat (5) step();
        chk("sb_drained", 64'(sb_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures the interval, in clk cycles, between consecutive rising edges of an asynchronous periodic input, such as an external tick or a baud-rate strobe.
- It is the measuring end of the team's periodic tick generation: the generator emits a tick every N cycles, and this block recovers N.
- Results are offered on a valid/ready output port.
- Used for clock/tick self-check and for auto-baud style calibration.

Parameters:
- NUM_BITS, 16, width of the period counter and of the result.
- SYNC_STAGES, 2, number of synchronizer flops on event_in (minimum 2).

Ports:
- clk  input  1  system clock.
- n_rst  input  1  asynchronous active-low reset.
- clear  input  1  synchronous; abandons the current measurement, drops any pending result, clears overrun.
- event_in  input  1  asynchronous event line; a rising edge marks a period boundary.
- period  output  NUM_BITS  measured cycles between the last two edges; saturates at all-ones.
- period_sat  output  1  qualifies period: the interval reached or exceeded 2^NUM_BITS-1 cycles.
- period_valid  output  1  period/period_sat hold a result not yet consumed.
- period_ready  input  1  consumer accepts the result on a cycle where valid && ready.
- overrun  output  1  sticky; a completed result was discarded because the previous result was still pending.

Behaviour:
- Reset (n_rst low, asynchronous):
  - Synchronizer flops and edge-detect history go to 0.
  - Counter goes to 0 and state goes to IDLE.
  - period=0, period_sat=0, period_valid=0, overrun=0.
- Synchronizer: event_in passes through SYNC_STAGES flops, then one history flop.
  - edge_pulse = last sync stage & ~history.
  - A rising edge of event_in that meets setup before clock edge k produces edge_pulse during the cycle after edge k+SYNC_STAGES-1.
- State machine (enum state_t):
  - IDLE: waiting for the first edge; counter holds 0. edge_pulse -> MEASURE, counter<=1.
  - MEASURE: counter <= counter+1 each cycle, saturating at 2^NUM_BITS-1 (no wrap).
  - On edge_pulse in MEASURE: the current counter value is the result; counter<=1; stay in MEASURE.
  - Consecutive edges detected at cycles t and t+P therefore produce result P.
  - The minimum reportable P is 2, because edge detection needs a low cycle in between.
- Result capture, at a MEASURE edge_pulse:
  - If period_valid=0, or period_valid=1 with period_ready=1 in the same cycle: period<=counter, period_sat<=(counter==all-ones), period_valid<=1 on the next edge. Simultaneous accept and new result means the new result replaces the old with no bubble.
  - If period_valid=1 and period_ready=0: the new result is discarded, period is held unchanged, and overrun<=1.
- Handshake:
  - period_valid stays high, with period/period_sat stable, until valid && ready; it deasserts on the following edge unless the capture rule above reloads it.
  - period_ready while period_valid=0 has no effect.
- Latency: event_in rising edge to period_valid high is SYNC_STAGES+1 clock edges (3 with defaults).
- clear: highest priority among synchronous controls.
  - State goes to IDLE and counter to 0.
  - period_valid<=0 and overrun<=0.
  - period and period_sat hold their values.
  - An edge_pulse in the same cycle is ignored.
  - The synchronizer keeps running, so a level already high does not produce a spurious edge after clear.
- Saturation: once the counter reaches all-ones it stays there until the next edge, which reports period=all-ones, period_sat=1. No timeout returns the block to IDLE.
- Arithmetic: unsigned, NUM_BITS wide. The increment is guarded by (counter != all-ones); no carry-out is used.

Decomposition:
- Package period_meter_pkg: state_t enum {IDLE, MEASURE} and localparam MIN_PERIOD=2.
- One sub-module, sync_edge_detect, parameterised by SYNC_STAGES, with ports clk, n_rst, async_in, level, rise_pulse. It is reusable for other asynchronous inputs.
- The counter, FSM and output register live in the top module.

Test Plan:
- After reset, with event_in=0 and period_ready=1: all outputs 0 for 20 cycles, no period_valid.
- Ticks every 100 cycles, period_ready=1:
  - The first edge produces no result.
  - Each later edge gives period=100, period_sat=0, with valid exactly 3 cycles after the event_in rise.
- NUM_BITS=8, ticks 300 cycles apart -> period=255, period_sat=1.
- Ticks every 10 cycles with period_ready held low:
  - The first result (10) is held.
  - The next edge sets overrun=1 while period stays 10.
  - Raising ready for one cycle drops valid.
  - clear drops overrun to 0.
- Valid pending, and ready asserted in the same cycle as a new edge_pulse with P=7 -> valid stays high and period updates to 7 with no gap.
- clear mid-measure, 40 cycles after an edge, with event_in high -> no result on the next edge. The second edge after clear reports the true interval.
- n_rst pulsed low mid-measure -> outputs 0 immediately (asynchronous). Measurement restarts from IDLE.
